uivtc_timing_gen: RTL and testbench
===================================

// Module: uivtc_timing_gen
// PURPOSE
//  Video timing controller. Generates VS/HS/DE raster timing from parameterised porch/sync/active widths.
//  Sits directly upstream of the test-pattern generator (uitpg_*) and the HDMI/RGB output path, which consume its outputs.
//  Also emits active-area pixel coordinates and a start-of-frame pulse so downstream stages need no counters of their own.
// PARAMETERS
//  H_ACTIVE  1920  active pixels per line
//  H_FP      88    horizontal front porch, in pixel clocks
//  H_SYNC    44    HS pulse width, in pixel clocks
//  H_BP      148   horizontal back porch, in pixel clocks
//  V_ACTIVE  1080  active lines per frame
//  V_FP      4     vertical front porch, in lines
//  V_SYNC    5     VS pulse width, in lines
//  V_BP      36    vertical back porch, in lines
//  HS_POL    1     HS active level (1 = active-high)
//  VS_POL    1     VS active level (1 = active-high)
// PORTS
//  I_vtc_clk   in   1   pixel clock; sole clock domain
//  I_vtc_rstn  in   1   asynchronous active-low reset
//  I_vtc_en    in   1   run enable; low holds the raster at frame origin
//  O_vtc_vs    out  1   vertical sync, polarity set by VS_POL
//  O_vtc_hs    out  1   horizontal sync, polarity set by HS_POL
//  O_vtc_de    out  1   active video (data enable), active-high
//  O_vtc_sof   out  1   1-cycle pulse at raster origin (h=0, v=0)
//  O_vtc_x     out  12  active-area column, 0..H_ACTIVE-1; 0 when DE is low
//  O_vtc_y     out  12  active-area row, 0..V_ACTIVE-1; 0 when DE is low
// BEHAVIOUR
//  - Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP. Both totals must be <= 4096.
//  - Line phase order: SYNC -> BP -> ACTIVE -> FP -> SYNC. Frame phase order is the same, counted in lines.
//  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
//  - v_cnt increments only on the cycle where h_cnt == H_TOTAL-1. It wraps to 0 when it is also V_TOTAL-1.
//  - Per-counter phase FSM states: SYNC, BP, ACT, FP. A transition occurs on the last count of each phase.
//    The FSM state is derived from the counter compare, not tracked independently.
//  - hs active  <=> h_cnt < H_SYNC.
//  - vs active  <=> v_cnt < V_SYNC. VS changes only on the line boundary, coincident with the HS leading edge.
//  - de         <=> h in ACT and v in ACT.
//  - sof        <=> h_cnt==0 and v_cnt==0.
//  - x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP) while DE is high; both are forced to 0 otherwise.
//  - All outputs are registered. Latency is 1 clock from counter state to output.
//    All outputs for a given (h,v) update on the same edge; there is no skew between VS, HS and DE.
//  - Reset (async assert, at any time including mid-frame):
//    - counters = 0;
//    - O_vtc_hs = ~HS_POL; O_vtc_vs = ~VS_POL;
//    - O_vtc_de = 0; O_vtc_sof = 0; O_vtc_x = 0; O_vtc_y = 0.
//  - Reset deassert with I_vtc_en=1: the first edge outputs the origin (sync active, sof=1). Counting proceeds from there.
//  - I_vtc_en = 0, sampled at any clock:
//    - counters are cleared to 0 and held;
//    - outputs take their reset values on the next edge;
//    - on re-enable, the raster restarts at origin with the same timing as after reset.
//  - No partial frames or truncated lines are emitted except where reset or disable aborts one.
//  - Counter widths are 12 bits. Arithmetic is unsigned, and comparisons use parameter-derived constants.
// STRUCTURE
//  - Shared package uivtc_pkg: preset localparams for 1280x720@60 and 1920x1080@60, and the phase-state encoding (2 bits).
//  - One sub-module, uivtc_axis_cnt, instantiated twice (H, then V):
//    - parameters SYNC/BP/ACT/FP;
//    - inputs clk, rstn, clr, step;
//    - outputs cnt, last, in_sync, in_act.
//  - The top level holds the output register stage, x/y subtraction, and the sof decode only.
// TESTING (small params: H 2/3/8/2 -> H_TOTAL=15, V 1/1/4/1 -> V_TOTAL=7; frame = 105 clocks)
//  1. Release reset with en=1 -> sof=1 and hs=vs=1 on the first edge.
//     hs high 2 clocks every 15; vs high for exactly 15 clocks every 105.
//  2. Active window -> first DE occurs 5 clocks after the start of line 2 (v_cnt=2). DE runs 8 clocks on lines 2..5 only.
//     32 DE cycles per frame; x steps 0..7 and y steps 0..3.
//  3. Outside DE -> x=y=0. The last active pixel of the frame shows x=7, y=3. The next cycle shows DE=0, x=0, y=0.
//  4. Assert rstn low at h_cnt=9, v_cnt=3 (mid-DE) -> all outputs go inactive without waiting for a clock edge.
//     After release, the raster restarts at origin identically to scenario 1.
//  5. Drop en for 20 clocks mid-frame -> outputs inactive from the next edge.
//     Re-raise en -> sof at the next edge, then a full 105-clock frame.
//  6. Set HS_POL=0, VS_POL=0 -> sync waveforms are the exact inverse of scenario 1. DE, sof and x/y are unchanged.
//     Also run the 1080p preset for 2 frames -> 2200x1125 clocks per frame and 1920x1080 DE cycles.

Source files
------------

// File: rtl/uivtc_pkg.sv
// Shared definitions for the video timing controller: raster presets,
// counter width and the per-axis phase encoding.
package uivtc_pkg;

  // Raster counters are 12 bits wide, so each axis total must be <= 4096.
  localparam int CNT_W = 12;

  // 1280x720@60 preset
  localparam int P720_H_ACTIVE = 1280;
  localparam int P720_H_FP     = 110;
  localparam int P720_H_SYNC   = 40;
  localparam int P720_H_BP     = 220;
  localparam int P720_V_ACTIVE = 720;
  localparam int P720_V_FP     = 5;
  localparam int P720_V_SYNC   = 5;
  localparam int P720_V_BP     = 20;

  // 1920x1080@60 preset
  localparam int P1080_H_ACTIVE = 1920;
  localparam int P1080_H_FP     = 88;
  localparam int P1080_H_SYNC   = 44;
  localparam int P1080_H_BP     = 148;
  localparam int P1080_V_ACTIVE = 1080;
  localparam int P1080_V_FP     = 4;
  localparam int P1080_V_SYNC   = 5;
  localparam int P1080_V_BP     = 36;

  // Phase of one raster axis, in the order the counter walks through them.
  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } phase_e;

  // Total count of one axis (pixels per line or lines per frame).
  function automatic int axis_total(input int sync_w, input int bp_w,
                                    input int act_w, input int fp_w);
    return sync_w + bp_w + act_w + fp_w;
  endfunction

endpackage

// File: rtl/uivtc_axis_cnt.sv
// One raster axis: a wrapping counter plus its SYNC/BP/ACT/FP phase,
// which is decoded from the count rather than tracked separately.
module uivtc_axis_cnt
  import uivtc_pkg::*;
#(
  parameter int SYNC = 1,
  parameter int BP   = 1,
  parameter int ACT  = 1,
  parameter int FP   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             in_sync,
  output logic             in_act
);

  localparam int               TOTAL     = axis_total(SYNC, BP, ACT, FP);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] BP_START  = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BP);
  localparam logic [CNT_W-1:0] FP_START  = CNT_W'(SYNC + BP + ACT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  phase_e           phase;

  // Phase follows directly from where the counter sits in the axis.
  always_comb begin
    phase = PH_FP;
    if (cnt_q < BP_START) begin
      phase = PH_SYNC;
    end else if (cnt_q < ACT_START) begin
      phase = PH_BP;
    end else if (cnt_q < FP_START) begin
      phase = PH_ACT;
    end
  end

  // Next count: clear wins, otherwise advance on step and wrap after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign last    = (cnt_q == LAST_C);
  assign in_sync = (phase == PH_SYNC);
  assign in_act  = (phase == PH_ACT);

endmodule

// File: rtl/uivtc_timing_gen.sv
// Video timing controller top: horizontal and vertical axis counters, the
// sof/x/y decode and one output register stage so VS, HS, DE, sof and x/y
// for a given raster position leave on the same clock edge.
module uivtc_timing_gen
  import uivtc_pkg::*;
#(
  parameter int   H_ACTIVE = P1080_H_ACTIVE,
  parameter int   H_FP     = P1080_H_FP,
  parameter int   H_SYNC   = P1080_H_SYNC,
  parameter int   H_BP     = P1080_H_BP,
  parameter int   V_ACTIVE = P1080_V_ACTIVE,
  parameter int   V_FP     = P1080_V_FP,
  parameter int   V_SYNC   = P1080_V_SYNC,
  parameter int   V_BP     = P1080_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic             I_vtc_clk,
  input  logic             I_vtc_rstn,
  input  logic             I_vtc_en,
  output logic             O_vtc_vs,
  output logic             O_vtc_hs,
  output logic             O_vtc_de,
  output logic             O_vtc_sof,
  output logic [CNT_W-1:0] O_vtc_x,
  output logic [CNT_W-1:0] O_vtc_y
);

  localparam logic [CNT_W-1:0] X_OFS = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] Y_OFS = CNT_W'(V_SYNC + V_BP);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             h_in_sync;
  logic             h_in_act;
  logic             v_in_sync;
  logic             v_in_act;
  // End-of-frame flag from the V axis; sof decodes the origin directly instead.
  logic             v_last_unused;

  logic             vs_q, vs_d;
  logic             hs_q, hs_d;
  logic             de_q, de_d;
  logic             sof_q, sof_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;

  // Pixel counter: runs every clock while enabled.
  uivtc_axis_cnt #(
    .SYNC(H_SYNC),
    .BP  (H_BP),
    .ACT (H_ACTIVE),
    .FP  (H_FP)
  ) u_h_cnt (
    .clk    (I_vtc_clk),
    .rstn   (I_vtc_rstn),
    .clr    (~I_vtc_en),
    .step   (1'b1),
    .cnt    (h_cnt),
    .last   (h_last),
    .in_sync(h_in_sync),
    .in_act (h_in_act)
  );

  // Line counter: advances once per line, on the last pixel of the line.
  uivtc_axis_cnt #(
    .SYNC(V_SYNC),
    .BP  (V_BP),
    .ACT (V_ACTIVE),
    .FP  (V_FP)
  ) u_v_cnt (
    .clk    (I_vtc_clk),
    .rstn   (I_vtc_rstn),
    .clr    (~I_vtc_en),
    .step   (h_last),
    .cnt    (v_cnt),
    .last   (v_last_unused),
    .in_sync(v_in_sync),
    .in_act (v_in_act)
  );

  // Output decode: inactive levels while disabled, raster decode otherwise.
  always_comb begin
    vs_d  = ~VS_POL;
    hs_d  = ~HS_POL;
    de_d  = 1'b0;
    sof_d = 1'b0;
    x_d   = '0;
    y_d   = '0;
    if (I_vtc_en) begin
      vs_d  = v_in_sync ? VS_POL : ~VS_POL;
      hs_d  = h_in_sync ? HS_POL : ~HS_POL;
      de_d  = h_in_act & v_in_act;
      sof_d = (h_cnt == '0) && (v_cnt == '0);
      if (h_in_act && v_in_act) begin
        x_d = h_cnt - X_OFS;
        y_d = v_cnt - Y_OFS;
      end
    end
  end

  // Output register stage; reset drives every output to its inactive level.
  always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
    if (!I_vtc_rstn) begin
      vs_q  <= ~VS_POL;
      hs_q  <= ~HS_POL;
      de_q  <= 1'b0;
      sof_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      vs_q  <= vs_d;
      hs_q  <= hs_d;
      de_q  <= de_d;
      sof_q <= sof_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign O_vtc_vs  = vs_q;
  assign O_vtc_hs  = hs_q;
  assign O_vtc_de  = de_q;
  assign O_vtc_sof = sof_q;
  assign O_vtc_x   = x_q;
  assign O_vtc_y   = y_q;

endmodule

// File: tb/tb_uivtc_timing_gen.sv
// Testbench for uivtc_timing_gen. Small raster H 2/3/8/2 (15 clocks per line),
// V 1/1/4/1 (7 lines, 105 clocks per frame), in active-high and active-low sync
// versions side by side, plus the 1080p preset over its first two lines.
// Sample index n counts negedges after release: n shows raster position
// h = n % 15, v = (n / 15) % 7.
module tb_uivtc_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic en;
  logic hd_rstn;

  logic        vs, hs, de, sof;
  logic [11:0] x, y;
  logic        n_vs, n_hs, n_de, n_sof;
  logic [11:0] n_x, n_y;
  logic        hd_vs, hd_hs, hd_de, hd_sof;
  logic [11:0] hd_x, hd_y;

  uivtc_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .I_vtc_clk(clk), .I_vtc_rstn(rstn), .I_vtc_en(en),
    .O_vtc_vs(vs), .O_vtc_hs(hs), .O_vtc_de(de), .O_vtc_sof(sof),
    .O_vtc_x(x), .O_vtc_y(y)
  );

  uivtc_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .I_vtc_clk(clk), .I_vtc_rstn(rstn), .I_vtc_en(en),
    .O_vtc_vs(n_vs), .O_vtc_hs(n_hs), .O_vtc_de(n_de), .O_vtc_sof(n_sof),
    .O_vtc_x(n_x), .O_vtc_y(n_y)
  );

  uivtc_timing_gen dut_hd (
    .I_vtc_clk(clk), .I_vtc_rstn(hd_rstn), .I_vtc_en(en),
    .O_vtc_vs(hd_vs), .O_vtc_hs(hd_hs), .O_vtc_de(hd_de), .O_vtc_sof(hd_sof),
    .O_vtc_x(hd_x), .O_vtc_y(hd_y)
  );

  typedef struct packed {
    logic [7:0]  n;
    logic [27:0] exp;   // {vs, hs, de, sof, x, y}
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  int n_checks = 0;
  int n_fail   = 0;

  // per-frame statistics over samples n = 0..104
  int c_hs, c_vs, c_de, c_sof, c_xy_bad, c_inv_bad, s_x, s_y;

  function automatic logic [27:0] pk(input logic pvs, input logic phs, input logic pde,
                                     input logic psof, input logic [11:0] px,
                                     input logic [11:0] py);
    return {pvs, phs, pde, psof, px, py};
  endfunction

  function automatic vec_t mk(input int n, input logic pvs, input logic phs,
                              input logic pde, input logic psof, input int px,
                              input int py);
    vec_t v;
    v.n   = 8'(n);
    v.exp = pk(pvs, phs, pde, psof, 12'(px), 12'(py));
    return v;
  endfunction

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got vs/hs/de/sof=%b x=%0d y=%0d, required vs/hs/de/sof=%b x=%0d y=%0d",
               name, act[27:24], act[23:12], act[11:0], exp[27:24], exp[23:12], exp[11:0]);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Run ncyc samples from the origin, checking table entries and gathering stats.
  task automatic run_cycles(input int ncyc, input string tag);
    logic [27:0] e;
    c_hs = 0; c_vs = 0; c_de = 0; c_sof = 0;
    c_xy_bad = 0; c_inv_bad = 0; s_x = 0; s_y = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      for (int i = 0; i < NV; i++) begin
        if (int'(tbl[i].n) == n) begin
          e = tbl[i].exp;
          chk($sformatf("%s pos n=%0d", tag, n), pk(vs, hs, de, sof, x, y), e);
          chk($sformatf("%s inv n=%0d", tag, n), pk(n_vs, n_hs, n_de, n_sof, n_x, n_y),
              {~e[27], ~e[26], e[25:0]});
        end
      end
      if (n < 105) begin
        c_hs  += int'(hs);
        c_vs  += int'(vs);
        c_de  += int'(de);
        c_sof += int'(sof);
        if (de) begin
          s_x += int'(x);
          s_y += int'(y);
        end else if (x != 12'd0 || y != 12'd0) begin
          c_xy_bad++;
        end
        if (n_hs !== ~hs || n_vs !== ~vs || n_de !== de || n_sof !== sof ||
            n_x !== x || n_y !== y) c_inv_bad++;
      end
      $display("%s n=%0d vs=%b hs=%b de=%b sof=%b x=%0d y=%0d", tag, n, vs, hs, de, sof, x, y);
    end
  endtask

  task automatic frame_stats(input string tag);
    chk_int({tag, " hs_cycles"}, c_hs, 14);
    chk_int({tag, " vs_cycles"}, c_vs, 15);
    chk_int({tag, " de_cycles"}, c_de, 32);
    chk_int({tag, " sof_count"}, c_sof, 1);
    chk_int({tag, " x_sum"}, s_x, 112);
    chk_int({tag, " y_sum"}, s_y, 48);
    chk_int({tag, " xy_outside_de"}, c_xy_bad, 0);
    chk_int({tag, " inverse_pol"}, c_inv_bad, 0);
  endtask

  initial begin
    int bad;
    int hd_hs_c, hd_vs_c, hd_de_c, hd_sof_c;

    //          n    vs hs de sof x  y
    tbl[0]  = mk(0,   1, 1, 0, 1, 0, 0);
    tbl[1]  = mk(1,   1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(2,   1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(14,  1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(15,  0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(34,  0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(35,  0, 0, 1, 0, 0, 0);
    tbl[7]  = mk(42,  0, 0, 1, 0, 7, 0);
    tbl[8]  = mk(43,  0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(51,  0, 0, 1, 0, 1, 1);
    tbl[10] = mk(54,  0, 0, 1, 0, 4, 1);
    tbl[11] = mk(87,  0, 0, 1, 0, 7, 3);
    tbl[12] = mk(88,  0, 0, 0, 0, 0, 0);
    tbl[13] = mk(95,  0, 0, 0, 0, 0, 0);
    tbl[14] = mk(104, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(105, 1, 1, 0, 1, 0, 0);
    tbl[16] = mk(106, 1, 1, 0, 0, 0, 0);
    tbl[17] = mk(60,  0, 1, 0, 0, 0, 0);

    rstn = 1'b0; en = 1'b1; hd_rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset pos", pk(vs, hs, de, sof, x, y), pk(0, 0, 0, 0, 12'd0, 12'd0));
    chk("reset inv", pk(n_vs, n_hs, n_de, n_sof, n_x, n_y), pk(1, 1, 0, 0, 12'd0, 12'd0));
    chk("reset hd", pk(hd_vs, hd_hs, hd_de, hd_sof, hd_x, hd_y), pk(0, 0, 0, 0, 12'd0, 12'd0));

    // Release reset, one full frame plus the start of the next.
    rstn = 1'b1;
    run_cycles(107, "s1");
    frame_stats("s1");

    // Restart from reset, run to h=9 v=3 (mid-DE), then reset asynchronously.
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_cycles(55, "s4pre");
    #1 rstn = 1'b0;
    #1;
    chk("async_rst pos", pk(vs, hs, de, sof, x, y), pk(0, 0, 0, 0, 12'd0, 12'd0));
    chk("async_rst inv", pk(n_vs, n_hs, n_de, n_sof, n_x, n_y), pk(1, 1, 0, 0, 12'd0, 12'd0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_cycles(107, "s4");
    frame_stats("s4");

    // Let the raster run into the frame, then disable for 20 clocks.
    repeat (30) @(negedge clk);
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pk(vs, hs, de, sof, x, y) !== pk(0, 0, 0, 0, 12'd0, 12'd0)) bad++;
      if (pk(n_vs, n_hs, n_de, n_sof, n_x, n_y) !== pk(1, 1, 0, 0, 12'd0, 12'd0)) bad++;
      $display("s5 hold %0d vs=%b hs=%b de=%b sof=%b", i, vs, hs, de, sof);
    end
    chk_int("s5 disabled_outputs_active", bad, 0);
    en = 1'b1;
    run_cycles(107, "s5");
    frame_stats("s5");

    // 1080p preset: first two lines (both inside vertical sync).
    hd_rstn = 1'b1;
    hd_hs_c = 0; hd_vs_c = 0; hd_de_c = 0; hd_sof_c = 0;
    for (int n = 0; n < 4400; n++) begin
      @(negedge clk);
      if (n == 0)
        chk("hd origin", pk(hd_vs, hd_hs, hd_de, hd_sof, hd_x, hd_y), pk(1, 1, 0, 1, 12'd0, 12'd0));
      if (n == 43)
        chk("hd hs_last", pk(hd_vs, hd_hs, hd_de, hd_sof, hd_x, hd_y), pk(1, 1, 0, 0, 12'd0, 12'd0));
      if (n == 44)
        chk("hd hs_end", pk(hd_vs, hd_hs, hd_de, hd_sof, hd_x, hd_y), pk(1, 0, 0, 0, 12'd0, 12'd0));
      if (n == 2199)
        chk("hd line_end", pk(hd_vs, hd_hs, hd_de, hd_sof, hd_x, hd_y), pk(1, 0, 0, 0, 12'd0, 12'd0));
      if (n == 2200)
        chk("hd line2_start", pk(hd_vs, hd_hs, hd_de, hd_sof, hd_x, hd_y), pk(1, 1, 0, 0, 12'd0, 12'd0));
      hd_hs_c  += int'(hd_hs);
      hd_vs_c  += int'(hd_vs);
      hd_de_c  += int'(hd_de);
      hd_sof_c += int'(hd_sof);
    end
    $display("hd 2 lines: hs=%0d vs=%0d de=%0d sof=%0d", hd_hs_c, hd_vs_c, hd_de_c, hd_sof_c);
    chk_int("hd hs_cycles", hd_hs_c, 88);
    chk_int("hd vs_cycles", hd_vs_c, 4400);
    chk_int("hd de_cycles", hd_de_c, 0);
    chk_int("hd sof_count", hd_sof_c, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
